// File: rtl/prn_gold_gen_if.sv
// Config, save/restore, control and chip-output bundle for one Gold-code PRN channel.
// The channel controller drives through master; the generator sits on slave.
interface prn_gold_gen_if #(
    parameter int LEN_WIDTH = 14
);
    logic                 prn_config_load_en;
    logic [9:0]           g2_init_i;
    logic [LEN_WIDTH-1:0] code_length_i;
    logic                 prn_state_load_en;
    logic [9:0]           g1_state_i;
    logic [9:0]           g2_state_i;
    logic [LEN_WIDTH-1:0] code_count_i;
    logic [9:0]           g1_state_o;
    logic [9:0]           g2_state_o;
    logic [LEN_WIDTH-1:0] code_count_o;
    logic                 phase_init;
    logic                 code_advance;
    logic                 prn_code;
    logic                 code_epoch;

    modport master (
        output prn_config_load_en, g2_init_i, code_length_i,
        output prn_state_load_en, g1_state_i, g2_state_i, code_count_i,
        output phase_init, code_advance,
        input  g1_state_o, g2_state_o, code_count_o, prn_code, code_epoch
    );

    modport slave (
        input  prn_config_load_en, g2_init_i, code_length_i,
        input  prn_state_load_en, g1_state_i, g2_state_i, code_count_i,
        input  phase_init, code_advance,
        output g1_state_o, g2_state_o, code_count_o, prn_code, code_epoch
    );
endinterface

// File: rtl/prn_gold_gen.sv
// G1/G2 Gold-code generator with chip counter and save/restore; one chip per code_advance.
// Loads/steps visible next cycle, prn_code combinational from state, code_epoch one cycle after wrap; no backpressure.
module prn_gold_gen #(
    parameter int LEN_WIDTH = 14
) (
    input  logic          clk,
    input  logic          rst_b,
    prn_gold_gen_if.slave bus
);
    logic [9:0]           g1_q, g1_d;
    logic [9:0]           g2_q, g2_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [9:0]           g2_init_q, g2_init_d;
    logic [LEN_WIDTH-1:0] length_q, length_d;
    logic                 epoch_q, epoch_d;

    always_comb begin
        g1_d      = g1_q;
        g2_d      = g2_q;
        count_d   = count_q;
        epoch_d   = 1'b0;
        g2_init_d = g2_init_q;
        length_d  = length_q;

        // Restarts below read g2_init_q, so a same-cycle config load only applies to later restarts.
        if (bus.prn_config_load_en) begin
            g2_init_d = bus.g2_init_i;
            length_d  = bus.code_length_i;
        end

        if (bus.prn_state_load_en) begin
            g1_d    = bus.g1_state_i;
            g2_d    = bus.g2_state_i;
            count_d = bus.code_count_i;
        end else if (bus.phase_init) begin
            g1_d    = 10'h3FF;
            g2_d    = g2_init_q;
            count_d = '0;
        end else if (bus.code_advance) begin
            if (count_q == length_q) begin
                g1_d    = 10'h3FF;
                g2_d    = g2_init_q;
                count_d = '0;
                epoch_d = 1'b1;
            end else begin
                g1_d    = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
                g2_d    = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
                count_d = count_q + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            g1_q      <= 10'h3FF;
            g2_q      <= 10'h3FF;
            count_q   <= '0;
            g2_init_q <= 10'h3FF;
            length_q  <= LEN_WIDTH'(1022);
            epoch_q   <= 1'b0;
        end else begin
            g1_q      <= g1_d;
            g2_q      <= g2_d;
            count_q   <= count_d;
            g2_init_q <= g2_init_d;
            length_q  <= length_d;
            epoch_q   <= epoch_d;
        end
    end

    assign bus.g1_state_o   = g1_q;
    assign bus.g2_state_o   = g2_q;
    assign bus.code_count_o = count_q;
    assign bus.prn_code     = g1_q[9] ^ g2_q[9];
    assign bus.code_epoch   = epoch_q;
endmodule

// File: tb/tb_prn_gold_gen.sv
// Directed bench for prn_gold_gen: reset, PRN1 chips, full period/epoch, save/restore, priority and config timing.
module tb_prn_gold_gen;
    localparam int LW = 14;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prn_gold_gen_if #(.LEN_WIDTH(LW)) bus ();

    prn_gold_gen #(.LEN_WIDTH(LW)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSRs written from the generator polynomials 1+x^3+x^10 and 1+x^2+x^3+x^6+x^8+x^9+x^10.
    function automatic logic [9:0] g1_next(input logic [9:0] g);
        logic fb;
        fb = g[9] ^ g[2];
        return {g[8:0], fb};
    endfunction

    function automatic logic [9:0] g2_next(input logic [9:0] g);
        logic fb;
        fb = g[9] ^ g[8] ^ g[7] ^ g[5] ^ g[2] ^ g[1];
        return {g[8:0], fb};
    endfunction

    task automatic idle_inputs();
        bus.prn_config_load_en = 1'b0;
        bus.prn_state_load_en  = 1'b0;
        bus.phase_init         = 1'b0;
        bus.code_advance       = 1'b0;
    endtask

    logic       ref_chip [0:1022];
    logic       rec_chip [0:36];
    logic [9:0] mg1, mg2, snap_g1, snap_g2;
    logic [LW-1:0] snap_cnt;
    logic [9:0] prn1_bits;
    int         ep_cnt;
    logic       last_ep;

    initial begin
        idle_inputs();
        bus.g2_init_i     = '0;
        bus.code_length_i = '0;
        bus.g1_state_i    = '0;
        bus.g2_state_i    = '0;
        bus.code_count_i  = '0;

        // Reset state
        #12;
        chk("rst_g1", bus.g1_state_o, 10'h3FF);
        chk("rst_g2", bus.g2_state_o, 10'h3FF);
        chk("rst_cnt", bus.code_count_o, 0);
        chk("rst_epoch", bus.code_epoch, 0);
        chk("rst_prn", bus.prn_code, 0);
        rst_b = 1'b1;
        tick();

        // PRN1 config then restart
        bus.prn_config_load_en = 1'b1;
        bus.g2_init_i          = 10'h0DF;
        bus.code_length_i      = 14'd1022;
        tick();
        bus.prn_config_load_en = 1'b0;
        chk("cfg_no_restart_g2", bus.g2_state_o, 10'h3FF);
        bus.phase_init = 1'b1;
        tick();
        bus.phase_init = 1'b0;
        chk("init_g2", bus.g2_state_o, 10'h0DF);
        chk("init_cnt", bus.code_count_o, 0);

        // First ten PRN1 chips: octal 1440
        prn1_bits = 10'b1100100000;
        bus.code_advance = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("prn1_chip%0d", i), bus.prn_code, prn1_bits[9-i]);
            tick();
        end
        bus.code_advance = 1'b0;
        chk("prn1_cnt10", bus.code_count_o, 10);

        // Full-period reference
        mg1 = 10'h3FF;
        mg2 = 10'h0DF;
        for (int k = 0; k < 1023; k++) begin
            ref_chip[k] = mg1[9] ^ mg2[9];
            mg1 = g1_next(mg1);
            mg2 = g2_next(mg2);
        end
        chk("model_period_g1", mg1, 10'h3FF);
        chk("model_period_g2", mg2, 10'h0DF);

        bus.phase_init = 1'b1;
        tick();
        bus.phase_init = 1'b0;
        bus.code_advance = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            ep_cnt = 0;
            last_ep = 1'b0;
            for (int k = 0; k < 1023; k++) begin
                chk($sformatf("period%0d_chip%0d", rep, k), bus.prn_code, ref_chip[k]);
                if (k == 500) chk($sformatf("period%0d_cnt500", rep), bus.code_count_o, 500);
                tick();
                ep_cnt += int'(bus.code_epoch);
                last_ep = bus.code_epoch;
            end
            chk($sformatf("period%0d_epoch_count", rep), ep_cnt, 1);
            chk($sformatf("period%0d_epoch_after_wrap", rep), last_ep, 1);
            chk($sformatf("period%0d_wrap_cnt", rep), bus.code_count_o, 0);
            chk($sformatf("period%0d_wrap_g1", rep), bus.g1_state_o, 10'h3FF);
            chk($sformatf("period%0d_wrap_g2", rep), bus.g2_state_o, 10'h0DF);
        end
        bus.code_advance = 1'b0;
        tick();
        chk("epoch_one_cycle", bus.code_epoch, 0);

        // Save / restore
        bus.code_advance = 1'b1;
        repeat (500) tick();
        bus.code_advance = 1'b0;
        mg1 = 10'h3FF;
        mg2 = 10'h0DF;
        for (int k = 0; k < 500; k++) begin
            mg1 = g1_next(mg1);
            mg2 = g2_next(mg2);
        end
        chk("save_cnt", bus.code_count_o, 500);
        chk("save_g1", bus.g1_state_o, mg1);
        chk("save_g2", bus.g2_state_o, mg2);
        snap_g1  = mg1;
        snap_g2  = mg2;
        snap_cnt = 14'd500;
        bus.code_advance = 1'b1;
        for (int j = 0; j < 37; j++) begin
            rec_chip[j] = bus.prn_code;
            chk($sformatf("pre_restore_chip%0d", j), bus.prn_code, ref_chip[500+j]);
            tick();
        end
        bus.code_advance = 1'b0;
        chk("run37_cnt", bus.code_count_o, 537);
        bus.prn_state_load_en = 1'b1;
        bus.g1_state_i   = snap_g1;
        bus.g2_state_i   = snap_g2;
        bus.code_count_i = snap_cnt;
        tick();
        bus.prn_state_load_en = 1'b0;
        chk("restore_g1", bus.g1_state_o, snap_g1);
        chk("restore_g2", bus.g2_state_o, snap_g2);
        chk("restore_cnt", bus.code_count_o, 500);
        bus.code_advance = 1'b1;
        for (int j = 0; j < 37; j++) begin
            chk($sformatf("replay_chip%0d", j), bus.prn_code, rec_chip[j]);
            tick();
        end
        bus.code_advance = 1'b0;

        // Priority: state load beats phase_init and advance
        bus.prn_state_load_en = 1'b1;
        bus.phase_init        = 1'b1;
        bus.code_advance      = 1'b1;
        bus.g1_state_i        = 10'h155;
        bus.g2_state_i        = 10'h2AA;
        bus.code_count_i      = 14'd1022;
        tick();
        idle_inputs();
        chk("prio_load_g1", bus.g1_state_o, 10'h155);
        chk("prio_load_g2", bus.g2_state_o, 10'h2AA);
        chk("prio_load_cnt", bus.code_count_o, 1022);
        chk("prio_load_no_epoch", bus.code_epoch, 0);
        chk("prio_load_prn", bus.prn_code, 1);

        // Priority: phase_init beats a wrapping advance, no epoch
        bus.phase_init   = 1'b1;
        bus.code_advance = 1'b1;
        tick();
        idle_inputs();
        chk("prio_init_cnt", bus.code_count_o, 0);
        chk("prio_init_g1", bus.g1_state_o, 10'h3FF);
        chk("prio_init_g2", bus.g2_state_o, 10'h0DF);
        chk("prio_init_no_epoch", bus.code_epoch, 0);

        // Config load coinciding with a wrap restarts with the old G2 init
        bus.prn_state_load_en = 1'b1;
        bus.code_count_i      = 14'd1022;
        tick();
        bus.prn_state_load_en  = 1'b0;
        bus.code_advance       = 1'b1;
        bus.prn_config_load_en = 1'b1;
        bus.g2_init_i          = 10'h2C6;
        bus.code_length_i      = 14'd1022;
        tick();
        idle_inputs();
        chk("cfgwrap_g2_old", bus.g2_state_o, 10'h0DF);
        chk("cfgwrap_cnt", bus.code_count_o, 0);
        chk("cfgwrap_epoch", bus.code_epoch, 1);
        bus.phase_init = 1'b1;
        tick();
        idle_inputs();
        chk("cfgwrap_init_g2_new", bus.g2_state_o, 10'h2C6);
        chk("cfgwrap_init_no_epoch", bus.code_epoch, 0);

        // Length 0: every advance wraps and pulses
        bus.prn_config_load_en = 1'b1;
        bus.code_length_i      = 14'd0;
        tick();
        idle_inputs();
        bus.code_advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("len0_epoch%0d", i), bus.code_epoch, 1);
            chk($sformatf("len0_cnt%0d", i), bus.code_count_o, 0);
        end
        bus.code_advance = 1'b0;

        // Out-of-range count keeps incrementing past length
        bus.prn_config_load_en = 1'b1;
        bus.code_length_i      = 14'd5;
        bus.prn_state_load_en  = 1'b1;
        bus.g1_state_i         = 10'h3FF;
        bus.g2_state_i         = 10'h2C6;
        bus.code_count_i       = 14'h3FFF;
        tick();
        idle_inputs();
        chk("oor_load_no_epoch", bus.code_epoch, 0);
        bus.code_advance = 1'b1;
        tick();
        chk("oor_wrap_mod", bus.code_count_o, 0);
        chk("oor_no_epoch", bus.code_epoch, 0);
        repeat (5) tick();
        chk("oor_reach_len", bus.code_count_o, 5);
        tick();
        chk("oor_resync_epoch", bus.code_epoch, 1);

        // Asynchronous reset clears a pending epoch
        bus.code_advance = 1'b0;
        chk("pre_reset_cnt", bus.code_count_o, 0);
        rst_b = 1'b0;
        #1;
        chk("async_rst_epoch", bus.code_epoch, 0);
        chk("async_rst_g2", bus.g2_state_o, 10'h3FF);
        chk("async_rst_g1", bus.g1_state_o, 10'h3FF);
        #5;
        rst_b = 1'b1;
        bus.phase_init = 1'b1;
        tick();
        idle_inputs();
        chk("rst_cfg_g2_init", bus.g2_state_o, 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prn_gold_gen.md
# prn_gold_gen

Gold-code PRN generator for GPS L1 C/A-class signals. It holds the G1/G2 10-stage LFSRs and a chip counter, and advances one chip per `code_advance` (the correlator code-NCO overflow). It drives `prn_code` into the correlator PRN bit pipeline and emits a code-epoch pulse to the NH/bit-sync logic. It also supports full state save and restore through the channel state buffer, so time-multiplexed channels can be context-switched.

## Interface
Parameters:
- LEN_WIDTH, 14, width of the code length and chip counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock
- rst_b  input  1  asynchronous active-low reset
- prn_config_load_en  input  1  latch `g2_init_i` and `code_length_i` into the config registers
- g2_init_i  input  10  G2 start state for this PRN (bit 9 = stage 10)
- code_length_i  input  LEN_WIDTH  code length minus 1 (1022 for C/A)
- prn_state_load_en  input  1  load G1, G2 and counter from the state inputs
- g1_state_i  input  10  G1 restore value
- g2_state_i  input  10  G2 restore value
- code_count_i  input  LEN_WIDTH  chip counter restore value
- g1_state_o  output  10  current G1
- g2_state_o  output  10  current G2
- code_count_o  output  LEN_WIDTH  current chip index
- phase_init  input  1  restart the code at chip 0
- code_advance  input  1  step one chip (NCO overflow)
- prn_code  output  1  current chip, G1[9]^G2[9], combinational from registers
- code_epoch  output  1  one-cycle pulse, registered

## Operation
- LFSR step, with shift toward bit 9:
  - G1 ← {G1[8:0], G1[2]^G1[9]}, which is 1+x^3+x^10.
  - G2 ← {G2[8:0], G2[1]^G2[2]^G2[5]^G2[7]^G2[8]^G2[9]}, which is 1+x^2+x^3+x^6+x^8+x^9+x^10.
- Per cycle, the chip/state registers take the first matching action in this priority order:
  1. `prn_state_load_en`: G1 ← `g1_state_i`, G2 ← `g2_state_i`, count ← `code_count_i`.
  2. `phase_init`: G1 ← 0x3FF, G2 ← g2_init_r, count ← 0.
  3. `code_advance` with count == length_r (wrap): G1 ← 0x3FF, G2 ← g2_init_r, count ← 0, and `code_epoch` is asserted next cycle.
  4. `code_advance` otherwise: step both LFSRs, count ← count+1.
  5. Otherwise, hold.
- `prn_config_load_en` acts independently of the list above and only updates g2_init_r/length_r.
  - If it coincides with `phase_init` or a wrap, the OLD g2_init_r is used for the restart; the new config takes effect on the next restart.
- Counter arithmetic is unsigned LEN_WIDTH, with no saturation.
  - If count > length_r (e.g., restored out-of-range), it increments and wraps modulo 2^LEN_WIDTH. It does not re-sync until it equals length_r.
- `code_epoch` fires only on a wrap via `code_advance`. It does not fire on `phase_init` or on a state load, even if the loaded count is 0.
- The `*_state_o` outputs reflect the registers directly, so save followed by restore is lossless.

## Timing
- Reset values:
  - G1 = 0x3FF, G2 = 0x3FF, count = 0.
  - g2_init_r = 0x3FF, length_r = 1022.
  - `prn_code` = 0; `code_epoch` = 0.
- `prn_code` is valid at the same cycle as the register state: the chip value for index n is present while count == n. A `code_advance` in cycle t shows the next chip in cycle t+1.
- `code_epoch`: a wrap step in cycle t gives `code_epoch` = 1 in cycle t+1 only. Back-to-back wraps with length 0 give a pulse every advancing cycle.
- Reset asserted mid-code clears everything asynchronously, including a pending epoch pulse.
- Loads are 1-cycle: the new state is visible on outputs the cycle after the load strobe.

## Test plan
- Reset -> g1_state_o = 0x3FF, g2_state_o = 0x3FF, code_count_o = 0, code_epoch = 0, prn_code = 0.
- Load config g2_init = 0x0DF and length 1022, pulse phase_init, then advance 10 times -> prn_code sequence 1,1,0,0,1,0,0,0,0,0 (PRN1 octal 1440).
- Continuous `code_advance` for 1023 chips -> code_epoch pulses exactly once, the cycle after the step where count = 1022. Then count = 0 and G1/G2 are back to 0x3FF/0x0DF, and the chip sequence repeats identically.
- Save and restore: advance 500 chips and snapshot the outputs, run 37 more chips, then assert prn_state_load_en with the snapshot -> outputs match the snapshot. The next 37 chips match the earlier 37.
- Priority:
  - prn_state_load_en + phase_init + code_advance in the same cycle -> the loaded state wins and there is no epoch.
  - phase_init + code_advance at count = 1022 -> count = 0 and no epoch.
- Config change during wrap: prn_config_load_en (g2_init = 0x2C6) in the same cycle as a wrap -> G2 = old 0x0DF. A following phase_init gives G2 = 0x2C6.
